// File: rtl/inst_realign_decomp_unit.sv
// Fetch-side halfword realignment buffer with RV32C expansion.
// Reassembles 32-bit instructions across fetch words and expands 16-bit ones.
module inst_realign_decomp_unit #(
  parameter int unsigned FETCH_HW = 2,
  parameter int unsigned BUF_HW   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [16*FETCH_HW-1:0]  i_fetch_data,
  input  logic                    i_fetch_valid,
  output logic                    o_fetch_ready,
  input  logic                    i_flush,
  input  logic [31:0]             i_flush_pc,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [31:0]             o_inst,
  output logic [31:0]             o_pc,
  output logic                    o_is_c,
  output logic                    o_illegal
);

  localparam int unsigned PW = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
  localparam int unsigned CW = $clog2(BUF_HW + 1);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [15:0]   hw_q [BUF_HW];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic          drop_q, drop_d;

  logic [15:0]   hw0, hw1;
  logic          is32, push, pop;
  logic [31:0]   exp_inst;
  logic          exp_ill;
  int unsigned   n_push, n_pop;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = (32'(p) + k) % BUF_HW;
    return s[PW-1:0];
  endfunction

  assign hw0  = hw_q[head_q];
  assign hw1  = hw_q[ptr_add(head_q, 1)];
  assign is32 = (hw0[1:0] == 2'b11);

  assign o_valid       = is32 ? (count_q >= CW'(2)) : (count_q != '0);
  assign o_fetch_ready = (32'(count_q) <= BUF_HW - FETCH_HW);
  assign push          = i_fetch_valid && o_fetch_ready && !i_flush;
  assign pop           = o_valid && i_ready && !i_flush;

  assign o_inst    = is32 ? {hw1, hw0} : exp_inst;
  assign o_pc      = pc_q;
  assign o_is_c    = !is32;
  assign o_illegal = !is32 && exp_ill;

  // RVC operand fields and scrambled immediates
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  imm6;
  logic [11:0] i6;
  logic [9:0]  imm_4spn, imm_16sp;
  logic [6:0]  imm_lw;
  logic [11:1] imm_j;
  logic [8:1]  imm_b;
  logic [7:0]  imm_lwsp, imm_swsp;

  assign rd       = hw0[11:7];
  assign rs2      = hw0[6:2];
  assign rdp      = {2'b01, hw0[4:2]};
  assign rs1p     = {2'b01, hw0[9:7]};
  assign imm6     = {hw0[12], hw0[6:2]};
  assign i6       = {{6{hw0[12]}}, imm6};
  assign imm_4spn = {hw0[10:7], hw0[12:11], hw0[5], hw0[6], 2'b00};
  assign imm_16sp = {hw0[12], hw0[4:3], hw0[5], hw0[2], hw0[6], 4'b0000};
  assign imm_lw   = {hw0[5], hw0[12:10], hw0[6], 2'b00};
  assign imm_j    = {hw0[12], hw0[8], hw0[10:9], hw0[6], hw0[7], hw0[2], hw0[11], hw0[5:3]};
  assign imm_b    = {hw0[12], hw0[6:5], hw0[2], hw0[11:10], hw0[4:3]};
  assign imm_lwsp = {hw0[3:2], hw0[12], hw0[6:4], 2'b00};
  assign imm_swsp = {hw0[8:7], hw0[12:9], 2'b00};

  always_comb begin
    exp_inst = '0;
    exp_ill  = 1'b0;
    case (hw0[1:0])
      2'b00: begin
        case (hw0[15:13])
          3'b000: begin
            if (imm_4spn == '0) exp_ill = 1'b1;
            else exp_inst = {2'b00, imm_4spn, 5'd2, 3'b000, rdp, OP_IMM};
          end
          3'b010: exp_inst = {5'b0, imm_lw, rs1p, 3'b010, rdp, OP_LD};
          3'b110: exp_inst = {5'b0, imm_lw[6:5], rdp, rs1p, 3'b010, imm_lw[4:0], OP_ST};
          default: exp_ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (hw0[15:13])
          3'b000: exp_inst = {i6, rd, 3'b000, rd, OP_IMM};
          3'b001, 3'b101: exp_inst = {imm_j[11], imm_j[10:1], imm_j[11], {8{imm_j[11]}},
                                      4'b0000, ~hw0[15], OP_JAL};
          3'b010: exp_inst = {i6, 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            if (rd == 5'd2) begin
              if (imm_16sp == '0) exp_ill = 1'b1;
              else exp_inst = {{2{hw0[12]}}, imm_16sp, 5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              if (imm6 == '0) exp_ill = 1'b1;
              else exp_inst = {{14{hw0[12]}}, imm6, rd, OP_LUI};
            end
          end
          3'b100: begin
            case (hw0[11:10])
              2'b00, 2'b01: begin
                if (hw0[12]) exp_ill = 1'b1;
                else exp_inst = {1'b0, hw0[10], 5'b0, rs2, rs1p, 3'b101, rs1p, OP_IMM};
              end
              2'b10: exp_inst = {i6, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                if (hw0[12]) exp_ill = 1'b1;
                else begin
                  case (hw0[6:5])
                    2'b00:   exp_inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                    2'b01:   exp_inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                    2'b10:   exp_inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                    default: exp_inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
                  endcase
                end
              end
            endcase
          end
          default: exp_inst = {imm_b[8], {3{imm_b[8]}}, imm_b[7:5], 5'd0, rs1p,
                               2'b00, hw0[13], imm_b[4:1], imm_b[8], OP_BR};
        endcase
      end
      2'b10: begin
        case (hw0[15:13])
          3'b000: begin
            if (hw0[12]) exp_ill = 1'b1;
            else exp_inst = {7'b0, rs2, rd, 3'b001, rd, OP_IMM};
          end
          3'b010: begin
            if (rd == '0) exp_ill = 1'b1;
            else exp_inst = {4'b0, imm_lwsp, 5'd2, 3'b010, rd, OP_LD};
          end
          3'b100: begin
            if (!hw0[12]) begin
              if (rs2 != '0) exp_inst = {7'b0, rs2, 5'd0, 3'b000, rd, OP_REG};
              else if (rd == '0) exp_ill = 1'b1;
              else exp_inst = {12'b0, rd, 3'b000, 5'd0, OP_JR};
            end else begin
              if (rs2 != '0) exp_inst = {7'b0, rs2, rd, 3'b000, rd, OP_REG};
              else if (rd == '0) exp_inst = 32'h00100073;
              else exp_inst = {12'b0, rd, 3'b000, 5'd1, OP_JR};
            end
          end
          3'b110: exp_inst = {4'b0, imm_swsp[7:5], rs2, 5'd2, 3'b010, imm_swsp[4:0], OP_ST};
          default: exp_ill = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    n_push  = push ? (FETCH_HW - (drop_q ? 1 : 0)) : 0;
    n_pop   = pop ? (is32 ? 2 : 1) : 0;
    head_d  = ptr_add(head_q, n_pop);
    tail_d  = ptr_add(tail_q, n_push);
    count_d = CW'(32'(count_q) + n_push - n_pop);
    pc_d    = pop ? (pc_q + (is32 ? 32'd4 : 32'd2)) : pc_q;
    drop_d  = push ? 1'b0 : drop_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = i_flush_pc & ~32'h1;
      drop_d  = (FETCH_HW > 1) ? i_flush_pc[1] : 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // A pending drop discards halfword 0 and packs the rest from the tail.
  always_ff @(posedge i_clk) begin
    if (push) begin
      for (int unsigned i = 0; i < FETCH_HW; i++) begin
        if (!(drop_q && i == 0))
          hw_q[ptr_add(tail_q, drop_q ? i - 1 : i)] <= i_fetch_data[16*i +: 16];
      end
    end
  end

endmodule

// File: tb/tb_inst_realign_decomp_unit.sv
// Directed bench for inst_realign_decomp_unit: expansion table plus buffering sequences.
module tb_inst_realign_decomp_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_data;
  logic        fetch_valid, fetch_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        valid, ready;
  logic [31:0] inst, pc;
  logic        is_c, illegal;

  int checks = 0;
  int errors = 0;

  inst_realign_decomp_unit #(
    .FETCH_HW(2),
    .BUF_HW  (6),
    .RESET_PC(32'h0)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fetch_data (fetch_data),
    .i_fetch_valid(fetch_valid),
    .o_fetch_ready(fetch_ready),
    .i_flush      (flush),
    .i_flush_pc   (flush_pc),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_inst       (inst),
    .o_pc         (pc),
    .o_is_c       (is_c),
    .o_illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hw;
    logic [31:0] inst;
    logic        ill;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] target);
    flush    = 1'b1;
    flush_pc = target;
    tick();
    flush    = 1'b0;
  endtask

  // c.li a0,k and its expansion addi a0,x0,k
  function automatic logic [15:0] cli(input int k);
    return 16'h4501 | 16'(k << 2);
  endfunction
  function automatic logic [31:0] cli_x(input int k);
    return 32'h00000513 | 32'(k << 20);
  endfunction

  initial begin
    vecs[0]  = '{16'h4505, 32'h00100513, 1'b0};
    vecs[1]  = '{16'h9002, 32'h00100073, 1'b0};
    vecs[2]  = '{16'h0000, 32'h00000000, 1'b1};
    // c.srli with bit12 set (16'h1001 is c.addi, a legal hint)
    vecs[3]  = '{16'h9001, 32'h00000000, 1'b1};
    vecs[4]  = '{16'h0001, 32'h00000013, 1'b0};
    vecs[5]  = '{16'h0048, 32'h00410513, 1'b0};
    vecs[6]  = '{16'h4188, 32'h0005A503, 1'b0};
    vecs[7]  = '{16'hBFFD, 32'hFFFFF06F, 1'b0};
    vecs[8]  = '{16'hC501, 32'h00050463, 1'b0};
    vecs[9]  = '{16'h6585, 32'h000015B7, 1'b0};
    vecs[10] = '{16'h6581, 32'h00000000, 1'b1};
    vecs[11] = '{16'h852E, 32'h00B00533, 1'b0};
    vecs[12] = '{16'h8D0D, 32'h40B50533, 1'b0};
    vecs[13] = '{16'hC22A, 32'h00A12223, 1'b0};
    vecs[14] = '{16'h4002, 32'h00000000, 1'b1};
    vecs[15] = '{16'h717D, 32'hFF010113, 1'b0};

    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    flush = 1'b0; flush_pc = '0; ready = 1'b0;
    #2;
    check("rst valid", valid, 0);
    check("rst fready", fetch_ready, 1);
    check("rst pc", pc, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle valid", valid, 0);
    check("idle fready", fetch_ready, 1);
    check("idle pc", pc, 0);

    // Full-width instruction, one cycle latency
    fetch_valid = 1'b1; fetch_data = 32'h00A00513; ready = 1'b1;
    check("t2 not early", valid, 0);
    tick();
    fetch_valid = 1'b0;
    check("t2 valid", valid, 1);
    check("t2 inst", inst, 32'h00A00513);
    check("t2 is_c", is_c, 0);
    check("t2 pc", pc, 0);
    tick();
    check("t2 empty", valid, 0);
    check("t2 pc+4", pc, 4);

    // Two compressed in one word
    flush_to(0);
    fetch_valid = 1'b1; fetch_data = {16'h4585, 16'h4505};
    tick();
    fetch_valid = 1'b0;
    check("t3 inst0", inst, 32'h00100513);
    check("t3 pc0", pc, 0);
    check("t3 c0", is_c, 1);
    tick();
    check("t3 inst1", inst, 32'h00100593);
    check("t3 pc1", pc, 2);
    check("t3 c1", is_c, 1);
    tick();
    check("t3 empty", valid, 0);

    // 32-bit instruction spanning two fetch words
    flush_to(0);
    fetch_valid = 1'b1; fetch_data = {16'h0513, 16'h4505};
    tick();
    fetch_valid = 1'b0;
    check("t4 inst0", inst, 32'h00100513);
    tick();
    check("t4 span wait", valid, 0);
    check("t4 span pc", pc, 2);
    tick();
    check("t4 span wait2", valid, 0);
    fetch_valid = 1'b1; fetch_data = {16'h0001, 16'h00A0};
    tick();
    fetch_valid = 1'b0;
    check("t4 span valid", valid, 1);
    check("t4 span inst", inst, 32'h00A00513);
    check("t4 span is_c", is_c, 0);
    check("t4 span pc2", pc, 2);
    tick();
    check("t4 nop", inst, 32'h00000013);
    check("t4 nop pc", pc, 6);
    tick();
    check("t4 empty", valid, 0);

    // Back-pressure: fill to capacity, then drain in order
    flush_to(0);
    ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("t5 fready%0d", w), fetch_ready, 1);
      fetch_valid = 1'b1; fetch_data = {cli(2*w+2), cli(2*w+1)};
      tick();
    end
    fetch_data = {cli(20), cli(20)};
    check("t5 full", fetch_ready, 0);
    tick(); tick();
    check("t5 still full", fetch_ready, 0);
    check("t5 hold inst", inst, cli_x(1));
    check("t5 hold pc", pc, 0);
    fetch_valid = 1'b0; ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("t5 drain inst%0d", k), inst, cli_x(k));
      check($sformatf("t5 drain pc%0d", k), pc, 32'(2*(k-1)));
      tick();
    end
    check("t5 no dup", valid, 0);

    // Flush wins over a same-cycle push; odd-halfword target drops hw0
    ready = 1'b0;
    fetch_valid = 1'b1; fetch_data = {cli(3), cli(3)};
    tick();
    flush = 1'b1; flush_pc = 32'h102; fetch_data = {cli(9), cli(9)};
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    check("t5 flush valid", valid, 0);
    check("t5 flush pc", pc, 32'h102);
    check("t5 flush fready", fetch_ready, 1);
    fetch_valid = 1'b1; fetch_data = {16'h4505, 16'hFFFF};
    tick();
    fetch_valid = 1'b0;
    check("t5 drop inst", inst, 32'h00100513);
    check("t5 drop pc", pc, 32'h102);
    check("t5 drop is_c", is_c, 1);
    ready = 1'b1;
    tick();
    check("t5 drop empty", valid, 0);
    check("t5 drop pc+2", pc, 32'h104);

    // Expansion table
    for (int i = 0; i < 16; i++) begin
      flush_to(32'h100);
      ready = 1'b0;
      fetch_valid = 1'b1; fetch_data = {16'h0001, vecs[i].hw};
      tick();
      fetch_valid = 1'b0;
      check($sformatf("vec%0d valid", i), valid, 1);
      check($sformatf("vec%0d inst", i), inst, vecs[i].inst);
      check($sformatf("vec%0d ill", i), illegal, vecs[i].ill);
      check($sformatf("vec%0d is_c", i), is_c, 1);
      check($sformatf("vec%0d pc", i), pc, 32'h100);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check($sformatf("vec%0d next pc", i), pc, 32'h102);
      check($sformatf("vec%0d next inst", i), inst, 32'h00000013);
    end

    // Streaming with simultaneous push and pop
    begin
      int w, idx;
      w = 0; idx = 0;
      flush_to(0);
      ready = 1'b1;
      for (int cyc = 0; cyc < 100 && idx < 16; cyc++) begin
        if (valid) begin
          check($sformatf("stream inst%0d", idx), inst, cli_x(idx + 1));
          check($sformatf("stream pc%0d", idx), pc, 32'(2*idx));
          idx++;
        end
        fetch_valid = (w < 8);
        fetch_data  = {cli(2*w+2), cli(2*w+1)};
        if (fetch_valid && fetch_ready) w++;
        tick();
      end
      fetch_valid = 1'b0;
      check("stream count", idx, 16);
      check("stream empty", valid, 0);
    end

    // PC wraps modulo 2^32
    flush_to(32'hFFFF_FFFC);
    ready = 1'b1;
    fetch_valid = 1'b1; fetch_data = {16'h4585, 16'h4505};
    tick();
    fetch_valid = 1'b0;
    check("wrap pc0", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap pc1", pc, 32'hFFFF_FFFE);
    check("wrap inst1", inst, 32'h00100593);
    tick();
    check("wrap pc2", pc, 32'h0);
    check("wrap empty", valid, 0);

    // Asynchronous reset mid-operation
    flush_to(32'h40);
    ready = 1'b0;
    fetch_valid = 1'b1; fetch_data = {16'h4585, 16'h4505};
    tick();
    fetch_valid = 1'b0;
    check("mid valid", valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid rst valid", valid, 0);
    check("mid rst pc", pc, 0);
    check("mid rst fready", fetch_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post rst valid", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
